// File: rtl/fm_pkg.sv
// Shared types and constants for the FM NCO: FSM state encoding, LFSR setup,
// default phase width.
package fm_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } fm_state_t;

  localparam int unsigned DefBitsPhase = 32;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1: taps on bits 15, 13, 12, 10.
  localparam logic [15:0] LfsrSeed = 16'hACE1;
  localparam logic [15:0] LfsrTaps = 16'hB400;

endpackage

// File: rtl/fm_nco_if.sv
// Control/data bundle between the audio front end and the FM NCO.
interface fm_nco_if
  import fm_pkg::*;
#(
  parameter int unsigned BITS_X         = 12,
  parameter int unsigned BITS_PHASE     = DefBitsPhase,
  parameter int unsigned PHASE_OUT_BITS = 8
);

  logic                      tx_en;
  logic                      sample_valid;
  logic [BITS_X-1:0]         sample_in;
  logic [BITS_PHASE-1:0]     carrier_inc;
  logic                      rf_out;
  logic [PHASE_OUT_BITS-1:0] phase_out;
  logic                      active;
  logic [1:0]                state_out;

  modport master (
    output tx_en, sample_valid, sample_in, carrier_inc,
    input  rf_out, phase_out, active, state_out
  );

  modport slave (
    input  tx_en, sample_valid, sample_in, carrier_inc,
    output rf_out, phase_out, active, state_out
  );

endinterface

// File: rtl/fm_ramp_fsm.sv
// Ramp FSM: fades the modulator gain in and out as tx_en changes, one gain
// step per sample strobe.
module fm_ramp_fsm
  import fm_pkg::*;
#(
  parameter int unsigned RAMP_BITS = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tx_en,
  input  logic               sample_valid,
  output logic [RAMP_BITS:0] gain,
  output logic               active,
  output logic [1:0]         state_out
);

  localparam logic [RAMP_BITS:0] GainMax = {1'b1, {RAMP_BITS{1'b0}}};

  fm_state_t          state_q, state_d;
  logic [RAMP_BITS:0] gain_q, gain_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gain_q  <= '0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
    end
  end

  // The gain step always follows the rule of the state present this cycle,
  // even when tx_en moves the FSM on the same edge.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    unique case (state_q)
      IDLE: begin
        gain_d = '0;
        if (tx_en) state_d = RAMP_UP;
      end
      RAMP_UP: begin
        if (sample_valid && (gain_q != GainMax)) gain_d = gain_q + 1'b1;
        if (!tx_en)                  state_d = RAMP_DOWN;
        else if (gain_d == GainMax)  state_d = RUN;
      end
      RUN: begin
        gain_d = GainMax;
        if (!tx_en) state_d = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (sample_valid && (gain_q != '0)) gain_d = gain_q - 1'b1;
        if (tx_en)              state_d = RAMP_UP;
        else if (gain_d == '0)  state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gain_d  = '0;
      end
    endcase
  end

  assign gain      = gain_q;
  assign active    = (state_q != IDLE);
  assign state_out = state_q;

endmodule

// File: rtl/fm_nco.sv
// FM modulator NCO: audio-scaled deviation added to a carrier increment drives
// a phase accumulator. Optional phase dither via `define FM_NCO_DITHER_EN.
module fm_nco
  import fm_pkg::*;
#(
  parameter int unsigned BITS_X         = 12,
  parameter int unsigned BITS_PHASE     = DefBitsPhase,
  parameter int unsigned DEV_SHIFT      = 8,
  parameter int unsigned RAMP_BITS      = 4,
  parameter int unsigned PHASE_OUT_BITS = 8
) (
  input logic   clock,
  input logic   reset,
  fm_nco_if.slave bus
);

  localparam int unsigned ProdBits = BITS_X + RAMP_BITS + 2;

  logic signed [BITS_X-1:0]     audio_q;
  logic [BITS_PHASE-1:0]        carrier_q;
  logic [BITS_PHASE-1:0]        inc_q, inc_d;
  logic [BITS_PHASE-1:0]        phase_q, phase_d;
  logic [BITS_PHASE-1:0]        dev;
  logic [RAMP_BITS:0]           gain;
  logic signed [RAMP_BITS+1:0]  gain_s;
  logic signed [ProdBits-1:0]   prod;
  logic signed [BITS_X:0]       scaled;
  logic                         active;
  logic                         rf_q;
  logic [PHASE_OUT_BITS-1:0]    phase_out_q;

  fm_ramp_fsm #(
    .RAMP_BITS (RAMP_BITS)
  ) u_fsm (
    .clock        (clock),
    .reset        (reset),
    .tx_en        (bus.tx_en),
    .sample_valid (bus.sample_valid),
    .gain         (gain),
    .active       (active),
    .state_out    (bus.state_out)
  );

  // Gain is unsigned, so it gets a zero sign bit before the signed multiply.
  always_comb begin
    gain_s = {1'b0, gain};
    prod   = ProdBits'(audio_q) * ProdBits'(gain_s);
    scaled = (BITS_X + 1)'(prod >>> RAMP_BITS);
    dev    = BITS_PHASE'(scaled) << DEV_SHIFT;
    inc_d  = carrier_q + dev;
  end

`ifdef FM_NCO_DITHER_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr_q <= LfsrSeed;
    end else if (active) begin
      lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LfsrTaps)};
    end
  end

  assign phase_d = phase_q + inc_q + BITS_PHASE'(lfsr_q[7:0]);
`else
  assign phase_d = phase_q + inc_q;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      audio_q     <= '0;
      carrier_q   <= '0;
      inc_q       <= '0;
      phase_q     <= '0;
      rf_q        <= 1'b0;
      phase_out_q <= '0;
    end else begin
      if (bus.sample_valid) begin
        audio_q   <= bus.sample_in;
        carrier_q <= bus.carrier_inc;
      end
      inc_q       <= inc_d;
      phase_q     <= active ? phase_d : '0;
      rf_q        <= phase_q[BITS_PHASE-1];
      phase_out_q <= phase_q[BITS_PHASE-1 -: PHASE_OUT_BITS];
    end
  end

  assign bus.rf_out    = rf_q;
  assign bus.phase_out = phase_out_q;
  assign bus.active    = active;

endmodule

// File: tb/tb_fm_nco.sv
// Scoreboard bench for fm_nco: each strobe queues its expected increment and
// state; a monitor checks them two clocks after the strobe.
module tb_fm_nco;

  localparam logic [31:0] C0 = 32'h4000_0000;

  typedef struct {
    string       name;
    logic [31:0] inc;
    logic [1:0]  st;
  } exp_t;

  logic clock;
  logic reset;
  int   tests;
  int   fails;
  exp_t sb[$];
  exp_t mon_e;
  logic sv_d1, sv_d2;
  logic [31:0] p0;
  logic [7:0]  po [8];
  logic        rf [8];
  int          ones;

  fm_nco_if bus ();

  fm_nco dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Called at posedge+1; one strobe cycle followed by seven quiet cycles.
  task automatic strobe(input string nm, input logic [11:0] s, input logic [31:0] c,
                        input logic [31:0] ei, input logic [1:0] es);
    exp_t e;
    e.name = nm;
    e.inc  = ei;
    e.st   = es;
    sb.push_back(e);
    bus.sample_in    = s;
    bus.carrier_inc  = c;
    bus.sample_valid = 1'b1;
    tick(1);
    bus.sample_valid = 1'b0;
    tick(7);
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      sv_d1 <= 1'b0;
      sv_d2 <= 1'b0;
    end else begin
      sv_d1 <= bus.sample_valid;
      sv_d2 <= sv_d1;
    end
  end

  always @(negedge clock) begin
    if (sv_d2) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_underflow: got strobe result with no expectation at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_inc"}, dut.inc_q, mon_e.inc);
        check({mon_e.name, "_state"}, 32'(bus.state_out), 32'(mon_e.st));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset            = 1'b1;
    bus.tx_en        = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    bus.carrier_inc  = C0;
    tests            = 0;
    fails            = 0;

    @(negedge clock);
    @(negedge clock);
    check("rst_state", 32'(bus.state_out), 32'd0);
    check("rst_active", 32'(bus.active), 32'd0);
    check("rst_rf", 32'(bus.rf_out), 32'd0);
    check("rst_phase_out", 32'(bus.phase_out), 32'd0);
    check("rst_inc", dut.inc_q, 32'd0);
    tick(1);
    reset = 1'b0;
    tick(1);

    strobe("idle", 12'h000, C0, C0, 2'd0);
    @(negedge clock);
    check("idle_rf", 32'(bus.rf_out), 32'd0);
    check("idle_phase", dut.phase_q, 32'd0);
    tick(1);

    bus.tx_en = 1'b1;
    @(negedge clock);
    check("active_early", 32'(bus.active), 32'd0);
    @(negedge clock);
    check("active_rise", 32'(bus.active), 32'd1);
    check("state_rampup", 32'(bus.state_out), 32'd1);
    tick(1);

    for (int i = 1; i <= 16; i++)
      strobe("rampup", 12'h000, C0, C0, (i == 16) ? 2'd2 : 2'd1);

`ifndef FM_NCO_DITHER_EN
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      rf[i] = bus.rf_out;
      po[i] = bus.phase_out;
      if (bus.rf_out) ones++;
    end
    check("rf_duty", 32'(ones), 32'd4);
    for (int i = 0; i < 4; i++) check("rf_period", 32'(rf[i + 4]), 32'(rf[i]));
    for (int i = 0; i < 7; i++) begin
      logic [7:0] d;
      d = po[i + 1] - po[i];
      check("phase_step", 32'(d), 32'h40);
    end
    tick(1);
`endif

    strobe("run_p1", 12'h001, C0, 32'h4000_0100, 2'd2);
    strobe("run_m1", 12'hFFF, C0, 32'h3FFF_FF00, 2'd2);
    strobe("wrap", 12'h001, 32'hFFFF_FF00, 32'h0000_0000, 2'd2);
`ifndef FM_NCO_DITHER_EN
    @(negedge clock);
    p0 = dut.phase_q;
    repeat (3) @(negedge clock);
    check("wrap_freeze", dut.phase_q, p0);
    tick(1);
`endif
    strobe("restore", 12'h000, C0, C0, 2'd2);

    bus.tx_en = 1'b0;
    tick(2);
    for (int i = 0; i < 7; i++) strobe("down", 12'h000, C0, C0, 2'd3);
    strobe("mid_7ff", 12'h7FF, C0, 32'h4003_FF00, 2'd3);
    strobe("down7", 12'h000, C0, C0, 2'd3);
    bus.tx_en = 1'b1;
    tick(2);
    strobe("mid_800", 12'h800, C0, 32'h3FFC_0000, 2'd1);
    for (int i = 1; i <= 8; i++)
      strobe("reup", 12'h000, C0, C0, (i == 8) ? 2'd2 : 2'd1);

    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("arst_state", 32'(bus.state_out), 32'd0);
    check("arst_active", 32'(bus.active), 32'd0);
    check("arst_rf", 32'(bus.rf_out), 32'd0);
    check("arst_phase_out", 32'(bus.phase_out), 32'd0);
    tick(2);
    reset = 1'b0;
    tick(2);
    check("restart_state", 32'(bus.state_out), 32'd1);
    for (int i = 0; i < 4; i++) strobe("restart", 12'h000, C0, C0, 2'd1);
    strobe("restart_g5", 12'h7FF, C0, 32'h4002_7F00, 2'd1);

    bus.tx_en = 1'b0;
    tick(2);
    for (int i = 1; i <= 5; i++)
      strobe("abort", 12'h000, C0, C0, (i == 5) ? 2'd0 : 2'd3);
    tick(3);
    @(negedge clock);
    check("abort_phase", dut.phase_q, 32'd0);
    check("abort_rf", 32'(bus.rf_out), 32'd0);
    check("abort_phase_out", 32'(bus.phase_out), 32'd0);
    check("abort_active", 32'(bus.active), 32'd0);
    tick(1);

    strobe("idle2", 12'h7FF, 32'h7000_0000, 32'h7000_0000, 2'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("idle2_rf", 32'(bus.rf_out), 32'd0);
    end

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fm_nco.md
Name: fm_nco

Overview:
- FM modulator stage directly downstream of the audio smoothing filter.
- Takes filtered signed audio samples and adds them, with a scaled deviation, to a programmable carrier phase increment.
- Runs a phase accumulator at the system clock and emits a 1-bit RF square wave plus coarse phase for a later sine LUT.
- A ramp FSM fades deviation and carrier in and out on tx_en changes to avoid clicks and splatter.

Parameters:
- BITS_X, 12: audio sample width, two's-complement.
- BITS_PHASE, 32: phase accumulator and increment width.
- DEV_SHIFT, 8: left shift applied to the scaled sample; sets frequency deviation per LSB.
- RAMP_BITS, 4: gain resolution. Gain runs 0..2**RAMP_BITS, one step per sample_valid.
- PHASE_OUT_BITS, 8: number of phase MSBs exported.

Ports:
- clock, in, 1: system clock.
- reset, in, 1: asynchronous, active-high.
- tx_en, in, 1: level; 1 requests transmit, 0 requests fade-out.
- sample_valid, in, 1: single-cycle strobe, audio sample rate.
- sample_in, in, BITS_X: signed audio from the smoothing filter.
- carrier_inc, in, BITS_PHASE: unsigned centre-frequency increment.
- rf_out, out, 1: registered phase MSB.
- phase_out, out, PHASE_OUT_BITS: registered phase[BITS_PHASE-1 -: PHASE_OUT_BITS].
- active, out, 1: high in RAMP_UP, RUN and RAMP_DOWN.
- state_out, out, 2: IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3.

Behaviour:
- Reset (async, any time, including mid-ramp):
  - state=IDLE, gain=0, audio_reg=0, inc_reg=0, phase=0.
  - rf_out=0, phase_out=0, active=0, state_out=0.
- Sample capture: on sample_valid, audio_reg<=sample_in and carrier_reg<=carrier_inc, in every state. With no strobe both hold.
- Gain update: on sample_valid, the FSM steps gain, using the state present in that cycle.
- Scaling (all signed arithmetic):
  - prod = audio_reg * gain, where gain is RAMP_BITS+1 bits, zero-extended.
  - scaled = prod >>> RAMP_BITS, BITS_X+1 bits, floor rounding.
  - dev = sext(scaled) << DEV_SHIFT, truncated to BITS_PHASE.
- inc_reg <= carrier_reg + dev, modulo 2**BITS_PHASE; overflow wraps silently.
- Phase: phase <= phase + inc_reg every clock when state != IDLE. In IDLE, phase is forced to 0.
- Outputs: rf_out and phase_out are registered from phase, one cycle after it.
- Latency:
  - sample_valid at cycle t: audio_reg valid at t+1, inc_reg at t+2, first phase step using it at t+3, visible on rf_out at t+4.
  - Gain change follows the same path.
- FSM:
  - IDLE: tx_en=1 -> RAMP_UP, gain=0.
  - RAMP_UP: gain+1 per sample_valid.
    - gain reaching 2**RAMP_BITS -> RUN.
    - tx_en=0 -> RAMP_DOWN, keeping current gain.
  - RUN: gain fixed at max; tx_en=0 -> RAMP_DOWN.
  - RAMP_DOWN: gain-1 per sample_valid.
    - tx_en=1 -> RAMP_UP from current gain.
    - gain reaching 0 -> IDLE.
  - If tx_en toggles in the same cycle as sample_valid, the transition happens and the gain step uses the old state's rule.
  - Gain saturates at both ends and never wraps.
- In IDLE, rf_out stays 0 regardless of sample_valid or carrier_inc.

Optional Feature:
- Macro: FM_NCO_DITHER_EN.
- Defined:
  - Adds a 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1.
  - Reset loads the seed. The LFSR advances every clock when state != IDLE.
  - Phase update becomes phase <= phase + inc_reg + zext(lfsr[7:0]), which spreads phase-truncation spurs.
- Undefined: no LFSR logic; phase update exactly as above.

Decomposition:
- Package fm_pkg:
  - state enum fm_state_t (IDLE, RAMP_UP, RUN, RAMP_DOWN).
  - LFSR seed and tap constants.
  - Default BITS_PHASE.
- Sub-module fm_ramp_fsm owns state, gain, active and state_out. fm_nco keeps the datapath and accumulator.

Test Plan:
- Defaults, tx_en=1, carrier_inc=32'h4000_0000, sample_in=0, sample_valid every 8 clocks:
  - active rises one clock after tx_en.
  - RUN after exactly 16 strobes.
  - rf_out period 4 clocks, 50% duty.
- RUN, sample_in=+1, carrier 32'h4000_0000: inc_reg=32'h4000_0100 two cycles after the strobe. sample_in=-1: inc_reg=32'h3FFF_FF00.
- Gain=8 mid-ramp:
  - sample_in=12'h7FF gives scaled=1023.
  - sample_in=12'h800 gives scaled=-1024.
  - inc_reg matches carrier+(scaled<<8).
- Wrap: carrier_inc=32'hFFFF_FF00, sample_in=+1, gain max: inc_reg=0 and phase freezes (no dither build).
- Abort: tx_en dropped at gain=5 in RAMP_UP gives RAMP_DOWN, then IDLE after 5 strobes; phase=0 and rf_out=0 thereafter.
- Reset asserted asynchronously mid-RUN: all outputs 0 within the same cycle, state_out=0. After release with tx_en=1, the ramp restarts from gain 0.
